// File: rtl/coo_aggregate_sched.sv
// -----------------------------------------------------------------------------
// coo_aggregate_sched
//
// Purpose:
//   Sequences GCN neighbour aggregation over a COO edge list (row,col pairs,
//   sorted by row). Each edge is read from the COO buffer and turned into one
//   aggregate request to the feature accumulator. Requests use a valid/ready
//   handshake, and the number of issued-but-unacked requests is credit limited.
//   The scheduler reports each finished row, counts finished rows and pulses
//   done at the end of a pass.
//
// Parameters:
//   EDGE_AW : COO buffer address width (max 2**EDGE_AW edges)
//   NODE_W  : node index width (row/col)
//   MAX_OUT : max issued-but-unacked aggregate requests (1..15)
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   start         in   launch a pass; only looked at while idle
//   num_edges     in   edge count, captured together with start
//   coo_rd_en     out  COO buffer read strobe
//   coo_rd_addr   out  COO buffer read address
//   coo_row       in   edge row, valid the cycle after coo_rd_en
//   coo_col       in   edge col, valid the cycle after coo_rd_en
//   agg_valid     out  aggregate request valid
//   agg_ready     in   accumulator accepts the request
//   agg_row       out  destination node of the request
//   agg_col       out  source node of the request
//   agg_ack       in   one-cycle completion pulse per accepted request
//   row_done      out  one-cycle pulse: all edges of row_done_idx issued+acked
//   row_done_idx  out  row index belonging to row_done
//   rows_done_cnt out  finished rows this pass, wraps modulo 2**NODE_W
//   busy          out  high whenever a pass is in progress
//   done          out  one-cycle pulse at the end of a pass
//   ack_err       out  sticky: agg_ack seen with nothing outstanding
// -----------------------------------------------------------------------------
module coo_aggregate_sched #(
  parameter int EDGE_AW = 6,
  parameter int NODE_W  = 3,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [EDGE_AW:0]   num_edges,
  output logic               coo_rd_en,
  output logic [EDGE_AW-1:0] coo_rd_addr,
  input  logic [NODE_W-1:0]  coo_row,
  input  logic [NODE_W-1:0]  coo_col,
  output logic               agg_valid,
  input  logic               agg_ready,
  output logic [NODE_W-1:0]  agg_row,
  output logic [NODE_W-1:0]  agg_col,
  input  logic               agg_ack,
  output logic               row_done,
  output logic [NODE_W-1:0]  row_done_idx,
  output logic [NODE_W-1:0]  rows_done_cnt,
  output logic               busy,
  output logic               done,
  output logic               ack_err
);

  // Four bits hold any credit limit in the supported 1..15 range.
  localparam int              OutW    = 4;
  localparam logic [OutW-1:0] MaxOutC = OutW'(MAX_OUT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    ISSUE,
    DRAIN,
    FIN
  } state_e;

  state_e              state_q, state_d;
  logic [EDGE_AW:0]    ptr_q, ptr_d;
  logic [EDGE_AW:0]    nedges_q, nedges_d;
  logic [NODE_W-1:0]   edge_row_q, edge_row_d;
  logic [NODE_W-1:0]   edge_col_q, edge_col_d;
  logic [OutW-1:0]     out_q, out_d;
  logic                have_prev_q, have_prev_d;
  logic [NODE_W-1:0]   prev_row_q, prev_row_d;
  logic                pend_q, pend_d;
  logic [NODE_W-1:0]   pend_row_q, pend_row_d;
  logic                row_done_q, row_done_d;
  logic [NODE_W-1:0]   row_done_idx_q, row_done_idx_d;
  logic [NODE_W-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                ack_err_q, ack_err_d;

  logic                hs;
  logic                ack_ok;
  logic                ack_bad;
  logic [EDGE_AW:0]    ptr_inc;

  // Issue is held off while credits are exhausted or while a finished row is
  // still waiting for its row_done. Neither condition can newly appear while
  // valid is already high (credits only return, and a row becomes pending
  // only on an accept), so a raised valid stays up until it is accepted.
  assign agg_valid = (state_q == ISSUE) && (out_q < MaxOutC) && !pend_q;
  assign hs        = agg_valid && agg_ready;
  assign ack_ok    = agg_ack && (out_q != '0);
  assign ack_bad   = agg_ack && (out_q == '0);
  assign ptr_inc   = ptr_q + 1'b1;

  assign coo_rd_en     = (state_q == FETCH);
  assign coo_rd_addr   = ptr_q[EDGE_AW-1:0];
  assign agg_row       = edge_row_q;
  assign agg_col       = edge_col_q;
  assign row_done      = row_done_q;
  assign row_done_idx  = row_done_idx_q;
  assign rows_done_cnt = cnt_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign ack_err       = ack_err_q;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    nedges_d       = nedges_q;
    edge_row_d     = edge_row_q;
    edge_col_d     = edge_col_q;
    out_d          = out_q;
    have_prev_d    = have_prev_q;
    prev_row_d     = prev_row_q;
    pend_d         = pend_q;
    pend_row_d     = pend_row_q;
    row_done_d     = 1'b0;
    row_done_idx_d = row_done_idx_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    ack_err_d      = ack_err_q;

    // A request and an ack in the same cycle cancel out; an ack with nothing
    // outstanding is flagged and does not underflow the counter.
    if (hs && !ack_ok) begin
      out_d = out_q + 1'b1;
    end else if (!hs && ack_ok) begin
      out_d = out_q - 1'b1;
    end
    if (ack_bad) begin
      ack_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d       = '0;
          nedges_d    = num_edges;
          cnt_d       = '0;
          ack_err_d   = 1'b0;
          have_prev_d = 1'b0;
          pend_d      = 1'b0;
          state_d     = (num_edges == '0) ? FIN : FETCH;
        end
      end

      FETCH: begin
        state_d = CAPT;
      end

      CAPT: begin
        edge_row_d = coo_row;
        edge_col_d = coo_col;
        state_d    = ISSUE;
      end

      ISSUE: begin
        if (hs) begin
          ptr_d       = ptr_inc;
          have_prev_d = 1'b1;
          prev_row_d  = edge_row_q;
          // The very first edge of a pass has no previous row to close.
          if (have_prev_q && (edge_row_q != prev_row_q)) begin
            pend_d     = 1'b1;
            pend_row_d = prev_row_q;
          end
          state_d = (ptr_inc < nedges_q) ? FETCH : DRAIN;
        end
      end

      DRAIN: begin
        // A still-pending earlier row is reported first (below); the last
        // row of the pass closes on the following cycle.
        if ((out_q == '0) && !pend_q) begin
          row_done_d     = 1'b1;
          row_done_idx_d = prev_row_q;
          cnt_d          = cnt_q + 1'b1;
          state_d        = FIN;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pending-row completion can land in any busy state once all requests
    // have drained.
    if ((state_q != IDLE) && pend_q && (out_q == '0)) begin
      row_done_d     = 1'b1;
      row_done_idx_d = pend_row_q;
      pend_d         = 1'b0;
      cnt_d          = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      nedges_q       <= '0;
      edge_row_q     <= '0;
      edge_col_q     <= '0;
      out_q          <= '0;
      have_prev_q    <= 1'b0;
      prev_row_q     <= '0;
      pend_q         <= 1'b0;
      pend_row_q     <= '0;
      row_done_q     <= 1'b0;
      row_done_idx_q <= '0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      ack_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      nedges_q       <= nedges_d;
      edge_row_q     <= edge_row_d;
      edge_col_q     <= edge_col_d;
      out_q          <= out_d;
      have_prev_q    <= have_prev_d;
      prev_row_q     <= prev_row_d;
      pend_q         <= pend_d;
      pend_row_q     <= pend_row_d;
      row_done_q     <= row_done_d;
      row_done_idx_q <= row_done_idx_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      ack_err_q      <= ack_err_d;
    end
  end

endmodule
